// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reprogramming sequencer: FSM state encoding,
// request/response records and small constant helpers.
// Latency: n/a (types only). Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BYPASS    = 3'd1,
        ST_PROGRAM   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_SWITCH    = 3'd5,
        ST_RESP      = 3'd6
    } pll_seq_state_e;

    // Request fields are stored at a fixed maximum width and cast down to
    // the instance parameters (index <= 8 bits, divider <= 32 bits).
    localparam int ReqIdxW = 8;
    localparam int ReqDivW = 32;

    typedef struct packed {
        logic [ReqIdxW-1:0] pll;
        logic [ReqDivW-1:0] div;
    } pll_req_t;

    typedef struct packed {
        logic valid;
        logic err;
    } pll_rsp_t;

    // Cycle-count parameters of 0 behave as 1.
    function automatic int eff(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Lock qualification: blanks lock after programming, counts consecutive
// lock-high cycles and the overall lock timeout. Flags are combinational
// on the counters, so the FSM reacts in the cycle the condition occurs.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start clears all
// counters (PROGRAM cycle); i_active marks WAIT_LOCK/SETTLE cycles; i_lock
// is the selected PLL's lock; o_lock_ok = lock seen outside blanking;
// o_done = settle run complete this cycle; o_timeout = last allowed cycle.
module pll_lock_monitor #(
    parameter int LockBlank    = 4,
    parameter int LockTimeout  = 1024,
    parameter int SettleCycles = 16,
    parameter int CntW         = 11
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_active,
    input  logic i_lock,
    output logic o_lock_ok,
    output logic o_done,
    output logic o_timeout
);

    logic [CntW-1:0] r_blank_cnt;
    logic [CntW-1:0] r_settle_cnt;
    logic [CntW-1:0] r_to_cnt;
    logic            w_blank;
    logic            w_lock_ok;

    // Blanking only applies right after programming; it is not re-armed
    // when SETTLE falls back to WAIT_LOCK.
    assign w_blank   = (r_blank_cnt != CntW'(LockBlank));
    assign w_lock_ok = i_active && !w_blank && i_lock;

    assign o_lock_ok = w_lock_ok;
    // The detecting WAIT_LOCK cycle counts as the first settle cycle.
    assign o_done    = w_lock_ok && (r_settle_cnt == CntW'(SettleCycles - 1));
    assign o_timeout = i_active && (r_to_cnt == CntW'(LockTimeout - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank_cnt  <= '0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
        end else if (i_start) begin
            r_blank_cnt  <= '0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
        end else if (i_active) begin
            if (w_blank) begin
                r_blank_cnt <= r_blank_cnt + CntW'(1);
            end
            // Timeout spans WAIT_LOCK and SETTLE and is never restarted
            // by a lock drop; the FSM leaves before it can wrap.
            r_to_cnt     <= r_to_cnt + CntW'(1);
            r_settle_cnt <= w_lock_ok ? (r_settle_cnt + CntW'(1)) : '0;
        end
    end

endmodule

// File: rtl/pll_seq_ctrl.sv
// Sequencer that safely reprograms one of NumPlls PLLs: bypass to ref, write divider, wait lock, switch back.
// Latency: SwitchCycles bypass + 1 program + lock/settle (<= LockTimeout) + SwitchCycles; bad index answers next cycle.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held in RESP until rsp_ready_i.
//
// Ports: clk_i, rst_ni (async active-low); req_valid_i/req_ready_o/req_pll_i/req_div_i
// request; rsp_valid_o/rsp_ready_i/rsp_err_o response; pll_div_o, pll_cfg_we_o,
// pll_lock_i, clk_sel_o per-PLL controls (clk_sel 1 = PLL output); busy_o.
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int                NumPlls      = 3,
    parameter int                DivWidth     = 8,
    parameter logic [DivWidth-1:0] DefaultDiv = 8'd1,
    parameter int                SwitchCycles = 4,
    parameter int                LockBlank    = 4,
    parameter int                LockTimeout  = 1024,
    parameter int                SettleCycles = 16,
    localparam int               IdxW         = (NumPlls > 1) ? $clog2(NumPlls) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [IdxW-1:0]                   req_pll_i,
    input  logic [DivWidth-1:0]               req_div_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic                              rsp_err_o,
    output logic [NumPlls-1:0][DivWidth-1:0]  pll_div_o,
    output logic [NumPlls-1:0]                pll_cfg_we_o,
    input  logic [NumPlls-1:0]                pll_lock_i,
    output logic [NumPlls-1:0]                clk_sel_o,
    output logic                              busy_o
);

    localparam int SwEff = eff(SwitchCycles);
    localparam int LbEff = eff(LockBlank);
    localparam int LtEff = eff(LockTimeout);
    localparam int StEff = eff(SettleCycles);
    localparam int MaxP  = max2(max2(SwEff, LbEff), max2(LtEff, StEff));
    localparam int CntW  = $clog2(MaxP) + 1;
    localparam logic [IdxW:0] NumPllsW = (IdxW + 1)'(NumPlls);

    pll_seq_state_e                     r_state;
    pll_req_t                           r_req;
    pll_rsp_t                           r_rsp;
    logic [CntW-1:0]                    r_sw_cnt;
    logic                               r_req_ready;
    logic                               r_busy;
    logic [NumPlls-1:0]                 r_clk_sel;
    logic [NumPlls-1:0][DivWidth-1:0]   r_div;
    logic [NumPlls-1:0]                 r_cfg_we;

    logic [IdxW-1:0] w_idx;
    logic            w_lock;
    logic            w_start;
    logic            w_active;
    logic            w_lock_ok;
    logic            w_done;
    logic            w_timeout;
    logic            w_bad_idx;
    logic            w_sw_last;

    assign w_idx     = IdxW'(r_req.pll);
    assign w_lock    = pll_lock_i[w_idx];
    assign w_start   = (r_state == ST_PROGRAM);
    assign w_active  = (r_state == ST_WAIT_LOCK) || (r_state == ST_SETTLE);
    assign w_bad_idx = ({1'b0, req_pll_i} >= NumPllsW);
    assign w_sw_last = (r_sw_cnt == CntW'(SwEff - 1));

    pll_lock_monitor #(
        .LockBlank    (LbEff),
        .LockTimeout  (LtEff),
        .SettleCycles (StEff),
        .CntW         (CntW)
    ) u_lock_mon (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_start   (w_start),
        .i_active  (w_active),
        .i_lock    (w_lock),
        .o_lock_ok (w_lock_ok),
        .o_done    (w_done),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_rsp       <= '0;
            r_sw_cnt    <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_clk_sel   <= '0;
            r_div       <= {NumPlls{DefaultDiv}};
            r_cfg_we    <= '0;
        end else begin
            // Write strobe is a single-cycle pulse.
            r_cfg_we <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_req.pll   <= ReqIdxW'(req_pll_i);
                        r_req.div   <= ReqDivW'(req_div_i);
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_bad_idx) begin
                            r_state <= ST_RESP;
                            r_rsp   <= '{valid: 1'b1, err: 1'b1};
                        end else begin
                            // Mux moves to ref from the first BYPASS cycle.
                            r_state              <= ST_BYPASS;
                            r_clk_sel[req_pll_i] <= 1'b0;
                            r_sw_cnt             <= '0;
                        end
                    end
                end
                ST_BYPASS: begin
                    if (w_sw_last) begin
                        r_state         <= ST_PROGRAM;
                        r_sw_cnt        <= '0;
                        r_div[w_idx]    <= DivWidth'(r_req.div);
                        r_cfg_we[w_idx] <= 1'b1;
                    end else begin
                        r_sw_cnt <= r_sw_cnt + CntW'(1);
                    end
                end
                ST_PROGRAM: begin
                    r_state <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK, ST_SETTLE: begin
                    // A settle run completing on the last allowed cycle wins.
                    if (w_done) begin
                        r_state  <= ST_SWITCH;
                        r_sw_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_RESP;
                        r_rsp   <= '{valid: 1'b1, err: 1'b1};
                    end else if (r_state == ST_WAIT_LOCK) begin
                        if (w_lock_ok) begin
                            r_state <= ST_SETTLE;
                        end
                    end else if (!w_lock) begin
                        r_state <= ST_WAIT_LOCK;
                    end
                end
                ST_SWITCH: begin
                    if (w_sw_last) begin
                        r_state          <= ST_RESP;
                        r_clk_sel[w_idx] <= 1'b1;
                        r_rsp            <= '{valid: 1'b1, err: 1'b0};
                    end else begin
                        r_sw_cnt <= r_sw_cnt + CntW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp       <= '0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp       <= '0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = r_req_ready;
    assign rsp_valid_o  = r_rsp.valid;
    assign rsp_err_o    = r_rsp.err;
    assign pll_div_o    = r_div;
    assign pll_cfg_we_o = r_cfg_we;
    assign clk_sel_o    = r_clk_sel;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: table of request vectors plus
// hand-written bad-index/backpressure, lock-glitch and reset sequences.
// Latencies are counted from the PROGRAM (strobe) cycle to the first RESP cycle.
module tb_pll_seq_ctrl;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_pll;
    logic [7:0]       req_div;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_err;
    logic [2:0][7:0]  pll_div;
    logic [2:0]       cfg_we;
    logic [2:0]       lock;
    logic [2:0]       clk_sel;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0][7:0] exp_div;
    logic [2:0]      exp_sel;

    typedef struct {
        logic [1:0] pll;
        logic [7:0] div;
        int         lock_from;   // lock high from PROGRAM+k onward, 0 = never
        int         exp_lat;     // PROGRAM cycle to first RESP cycle
        logic       exp_err;
    } vec_t;

    vec_t tbl[8];

    pll_seq_ctrl #(
        .NumPlls      (3),
        .DivWidth     (8),
        .DefaultDiv   (8'd1),
        .SwitchCycles (4),
        .LockBlank    (4),
        .LockTimeout  (64),
        .SettleCycles (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_pll_i    (req_pll),
        .req_div_i    (req_div),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_err_o    (rsp_err),
        .pll_div_o    (pll_div),
        .pll_cfg_we_o (cfg_we),
        .pll_lock_i   (lock),
        .clk_sel_o    (clk_sel),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] from_k(input int k);
        logic [127:0] ones;
        ones = '1;
        return (k == 0) ? '0 : (ones << k);
    endfunction

    task automatic run_req(input string nm, input logic [1:0] pll, input logic [7:0] div,
                           input logic [127:0] pat, input int exp_lat, input logic exp_err);
        int   ab;
        int   lat;
        int   extra;
        logic early;
        chk({nm, "/ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_pll   = pll;
        req_div   = div;
        tick();
        req_valid = 1'b0;
        chk({nm, "/bypass_sel"}, clk_sel[pll], 0);
        ab = 1;
        while (cfg_we == 3'b000 && ab < 20) begin
            tick();
            ab++;
        end
        chk({nm, "/strobe_lat"}, ab, 5);
        exp_div[pll] = div;
        exp_sel[pll] = 1'b0;
        chk({nm, "/strobe"}, cfg_we, 3'b001 << pll);
        chk({nm, "/div_prog"}, pll_div, exp_div);
        lock[pll] = pat[0];
        lat   = 0;
        extra = 0;
        early = 1'b0;
        for (int j = 1; j <= 120; j++) begin
            tick();
            lock[pll] = pat[j];
            if (cfg_we != 3'b000) extra++;
            if (rsp_valid) begin
                lat = j;
                break;
            end
            if (clk_sel[pll]) early = 1'b1;
        end
        if (!exp_err) exp_sel[pll] = 1'b1;
        chk({nm, "/rsp_lat"}, lat, exp_lat);
        chk({nm, "/rsp_err"}, rsp_err, exp_err);
        chk({nm, "/clk_sel"}, clk_sel, exp_sel);
        chk({nm, "/div_all"}, pll_div, exp_div);
        chk({nm, "/extra_strobe"}, extra, 0);
        chk({nm, "/early_sel"}, early, 0);
        chk({nm, "/busy_ready"}, {busy, req_ready}, 2'b10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        lock      = '0;
        chk({nm, "/idle"}, {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        logic [127:0] ones;
        logic [127:0] gpat;
        int   ab;
        logic seen;

        tbl[0] = '{2'd1, 8'h10, 10, 30, 1'b0};
        tbl[1] = '{2'd1, 8'h20, 10, 30, 1'b0};  // clk_sel[1] 1 -> 0 -> 1
        tbl[2] = '{2'd0, 8'h05,  2, 25, 1'b0};  // lock inside blanking window
        tbl[3] = '{2'd2, 8'hFF,  5, 25, 1'b0};  // first unblanked cycle
        tbl[4] = '{2'd2, 8'h33,  0, 65, 1'b1};  // never locks
        tbl[5] = '{2'd0, 8'h44, 40, 60, 1'b0};
        tbl[6] = '{2'd1, 8'h5A, 48, 68, 1'b0};  // settles one cycle before timeout
        tbl[7] = '{2'd1, 8'h6B, 50, 65, 1'b1};  // timeout while in SETTLE

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pll   = '0;
        req_div   = '0;
        rsp_ready = 1'b0;
        lock      = '0;
        exp_div   = {3{8'h01}};
        exp_sel   = '0;
        tick();
        tick();
        chk("reset_ctrl", {req_ready, busy, rsp_valid, rsp_err, cfg_we, clk_sel}, 10'b10_0000_0000);
        chk("reset_div", pll_div, 24'h010101);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {req_ready, busy, rsp_valid}, 3'b100);

        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].pll, tbl[i].div,
                    from_k(tbl[i].lock_from), tbl[i].exp_lat, tbl[i].exp_err);
        end

        // Bad index answered the next cycle, then held under backpressure.
        req_valid = 1'b1;
        req_pll   = 2'd3;
        req_div   = 8'hAA;
        tick();
        req_valid = 1'b0;
        chk("bad_rsp", {rsp_valid, rsp_err, busy}, 3'b111);
        chk("bad_no_strobe", cfg_we, 3'b000);
        chk("bad_sel", clk_sel, exp_sel);
        chk("bad_div", pll_div, exp_div);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), {rsp_valid, rsp_err, req_ready, cfg_we}, 6'b110_000);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release", {rsp_valid, rsp_err, busy, req_ready}, 4'b0001);

        // Lock high 8 cycles, low 1, then high: only the second run of 16 counts.
        ones = '1;
        gpat = ((ones << 6) & ~(ones << 14)) | (ones << 15);
        run_req("glitch", 2'd0, 8'h66, gpat, 35, 1'b0);

        // Reset while in WAIT_LOCK abandons the request silently.
        req_valid = 1'b1;
        req_pll   = 2'd1;
        req_div   = 8'h77;
        tick();
        req_valid = 1'b0;
        ab = 1;
        while (cfg_we == 3'b000 && ab < 20) begin
            tick();
            ab++;
        end
        chk("rst_mid/strobe_lat", ab, 5);
        tick();
        tick();
        tick();
        lock  = 3'b111;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/ctrl", {req_ready, busy, rsp_valid, rsp_err, cfg_we, clk_sel}, 10'b10_0000_0000);
        chk("rst_mid/div", pll_div, 24'h010101);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rsp_valid || busy || cfg_we != 3'b000) seen = 1'b1;
        end
        chk("rst_mid/quiet", seen, 0);
        chk("rst_mid/sel_low", clk_sel, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_seq_ctrl.md
PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 SHALL have parameter NumPlls, default 3, number of PLL/FLL instances controlled.
REQ-002 SHALL have parameter DivWidth, default 8, divider/multiplier config width.
REQ-003 SHALL have parameter DefaultDiv, default 8'd1, per-PLL divider after reset.
REQ-004 SHALL have parameter SwitchCycles, default 4, cycles the clock mux is held on ref before/after programming.
REQ-005 SHALL have parameter LockBlank, default 4, cycles lock is ignored after programming.
REQ-006 SHALL have parameter LockTimeout, default 1024, max WAIT_LOCK+SETTLE cycles before error.
REQ-007 SHALL have parameter SettleCycles, default 16, cycles lock must stay high continuously.
REQ-008 SHALL have ports: clk_i in 1 sole clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-009 SHALL have ports: req_valid_i in 1; req_ready_o out 1; req_pll_i in IdxW=max(1,$clog2(NumPlls)) target index; req_div_i in DivWidth new divider.
REQ-010 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_err_o out 1 (timeout or bad index).
REQ-011 SHALL have ports: pll_div_o out NumPlls x DivWidth; pll_cfg_we_o out NumPlls one-cycle write strobe; pll_lock_i in NumPlls lock; clk_sel_o out NumPlls (1 = PLL output, 0 = reference clock); busy_o out 1.

Function
REQ-012 SHALL implement FSM states IDLE, BYPASS, PROGRAM, WAIT_LOCK, SETTLE, SWITCH, RESP; one request in flight.
REQ-013 SHALL assert req_ready_o only in IDLE; request accepted on req_valid_i && req_ready_o, index/div latched that cycle.
REQ-014 SHALL, if req_pll_i >= NumPlls, go IDLE->RESP with rsp_err_o=1, no PLL output changed.
REQ-015 SHALL in BYPASS drive clk_sel_o[idx]=0 from the first BYPASS cycle and stay SwitchCycles cycles.
REQ-016 SHALL in PROGRAM (exactly 1 cycle) set pll_div_o[idx]=latched div and pulse pll_cfg_we_o[idx]=1; all other strobes 0 always.
REQ-017 SHALL in WAIT_LOCK ignore pll_lock_i for the first LockBlank cycles, then go SETTLE when pll_lock_i[idx]=1.
REQ-018 SHALL in SETTLE count consecutive lock-high cycles; on reaching SettleCycles go SWITCH; on lock drop return WAIT_LOCK with settle count cleared.
REQ-019 SHALL run one timeout counter from PROGRAM exit, not reset by SETTLE->WAIT_LOCK; at LockTimeout go RESP with rsp_err_o=1, clk_sel_o[idx] left 0.
REQ-020 SHALL in SWITCH hold SwitchCycles cycles then set clk_sel_o[idx]=1 on exit, go RESP with rsp_err_o=0.
REQ-021 SHALL in RESP hold rsp_valid_o=1 and rsp_err_o stable until rsp_ready_i, then IDLE; rsp_ready_i outside RESP ignored.
REQ-022 SHALL drive busy_o=1 in every state except IDLE.
REQ-023 SHALL never change clk_sel_o or pll_div_o of non-target PLLs.
REQ-024 SHALL count with saturating-free counters sized $clog2(max param)+1; params of 0 treated as 1.

Reset
REQ-025 SHALL on rst_ni=0 asynchronously enter IDLE, clear counters, set pll_div_o[*]=DefaultDiv, clk_sel_o=0, pll_cfg_we_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0.
REQ-026 SHALL on reset mid-operation abandon the request with no response generated.
REQ-027 SHALL keep clk_sel_o[i]=0 after reset until a successful request for PLL i.

Structure
REQ-028 SHALL place the FSM state enum and request/response structs in shared package pll_seq_pkg.
REQ-029 SHALL use one sub-module pll_lock_monitor (blanking, settle and timeout counters, done/timeout flags); FSM and config registers stay in the top.

Verification
REQ-030 SHALL test nominal: req pll=1 div=8'h20, lock rises 10 cycles after strobe -> strobe 1 cycle, clk_sel_o[1] 1->0->1, rsp_err_o=0, clk_sel_o[0],[2] unchanged.
REQ-031 SHALL test timeout: lock held 0, LockTimeout=64 -> rsp_valid_o with rsp_err_o=1 at cycle 64 after PROGRAM, clk_sel_o[idx]=0.
REQ-032 SHALL test lock glitch: lock high 8 cycles, low 1, high 16 -> SWITCH only after the second 16-cycle run.
REQ-033 SHALL test bad index: req pll=3 with NumPlls=3 -> RESP next cycle, rsp_err_o=1, no strobe.
REQ-034 SHALL test backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o/rsp_err_o stable, req_ready_o=0 throughout.
REQ-035 SHALL test reset mid-WAIT_LOCK -> all outputs at reset values, no response after reset release.
